// File: rtl/lc3b_types.sv
// -----------------------------------------------------------------------------
// lc3b_types
//   Shared widths, line/address typedefs and the memory-arbiter enums used by
//   mem_arbiter and iline_buffer.
// -----------------------------------------------------------------------------
package lc3b_types;

    localparam int LC3B_LINE_W = 128;   // one memory line
    localparam int LC3B_ADR_W  = 12;    // line address
    localparam int LC3B_SEL_W  = 16;    // one byte enable per line byte

    typedef logic [LC3B_LINE_W-1:0] lc3b_line;
    typedef logic [LC3B_LINE_W-1:0] lc3b_c_line;
    typedef logic [LC3B_ADR_W-1:0]  lc3b_wb_adr;
    typedef logic [LC3B_SEL_W-1:0]  lc3b_wb_sel;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IFILL = 2'd1,
        DACC  = 2'd2,
        DRESP = 2'd3
    } lc3b_arb_state;

    // Which requester received the most recent grant.
    typedef enum logic {
        GRANT_FETCH = 1'b0,
        GRANT_DATA  = 1'b1
    } lc3b_grant_t;

endpackage

// File: rtl/iline_buffer.sv
// -----------------------------------------------------------------------------
// iline_buffer
//   One-line instruction buffer: tag, valid and data registers with a fill
//   port, an address-qualified invalidate port and a combinational hit.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset (clears everything)
//   lookup_read_i     fetch request is active
//   lookup_addr_i     fetch line address to compare against the tag
//   hit_o             buffer holds lookup_addr_i (combinational)
//   data_o            buffered line, always driven
//   fill_i            load fill_addr_i / fill_data_i and mark valid
//   fill_addr_i       tag for the fill
//   fill_data_i       line for the fill
//   inv_i             invalidate if inv_addr_i matches the stored tag
//   inv_addr_i        address of a completed store
// -----------------------------------------------------------------------------
module iline_buffer
    import lc3b_types::*;
#(
    parameter int LINE_W = LC3B_LINE_W,
    parameter int ADR_W  = LC3B_ADR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lookup_read_i,
    input  logic [ADR_W-1:0]  lookup_addr_i,
    output logic              hit_o,
    output logic [LINE_W-1:0] data_o,
    input  logic              fill_i,
    input  logic [ADR_W-1:0]  fill_addr_i,
    input  logic [LINE_W-1:0] fill_data_i,
    input  logic              inv_i,
    input  logic [ADR_W-1:0]  inv_addr_i
);

    logic              valid_q, valid_d;
    logic [ADR_W-1:0]  tag_q,   tag_d;
    logic [LINE_W-1:0] data_q,  data_d;

    assign hit_o  = lookup_read_i & valid_q & (tag_q == lookup_addr_i);
    assign data_o = data_q;

    // Fill and invalidate come from different arbiter states, so they never
    // coincide; fill is given priority anyway so the intent is unambiguous.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_i) begin
            valid_d = 1'b1;
            tag_d   = fill_addr_i;
            data_d  = fill_data_i;
        end else if (inv_i && (inv_addr_i == tag_q)) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Multiplexes the instruction-fetch port and the MEM-stage data port onto a
//   single physical memory port. Fetches are served from a one-line buffer;
//   misses and data accesses are arbitrated round-robin.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   ifetch_read/_address       fetch request (may be held high forever)
//   ifetch_rdata/_resp         buffered line / combinational hit
//   mem_read/_write/_address   data request, held until mem_resp
//   mem_wdata/_sel             write line and byte enables
//   mem_rdata/_resp            read line (held) / one-cycle completion pulse
//   pmem_read/_write/_address  registered physical command
//   pmem_wdata/_sel            registered write data / byte enables (0 on reads)
//   pmem_rdata/_resp           physical read data / completion pulse
//   dbg_state_o                current arbiter state
//
// Handshake: a requester raises read/write with a stable address and holds it;
// the arbiter answers with a single-cycle resp. On the physical side a command
// stays asserted and unchanged until pmem_resp, and is dropped on the edge
// that samples pmem_resp. A data request still high after its mem_resp cycle
// is taken as a new access.
// -----------------------------------------------------------------------------
module mem_arbiter
    import lc3b_types::*;
#(
    parameter int LINE_W = LC3B_LINE_W,
    parameter int ADR_W  = LC3B_ADR_W,
    parameter int SEL_W  = LC3B_SEL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    // instruction fetch port
    input  logic              ifetch_read,
    input  logic [ADR_W-1:0]  ifetch_address,
    output logic [LINE_W-1:0] ifetch_rdata,
    output logic              ifetch_resp,
    // data port
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADR_W-1:0]  mem_address,
    input  logic [LINE_W-1:0] mem_wdata,
    input  logic [SEL_W-1:0]  mem_sel,
    output logic [LINE_W-1:0] mem_rdata,
    output logic              mem_resp,
    // physical memory port
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADR_W-1:0]  pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    output logic [SEL_W-1:0]  pmem_sel,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    // debug
    output lc3b_arb_state     dbg_state_o
);

    lc3b_arb_state     state_q,        state_d;
    lc3b_grant_t       last_grant_q,   last_grant_d;
    logic              pmem_read_q,    pmem_read_d;
    logic              pmem_write_q,   pmem_write_d;
    logic [ADR_W-1:0]  pmem_address_q, pmem_address_d;
    logic [LINE_W-1:0] pmem_wdata_q,   pmem_wdata_d;
    logic [SEL_W-1:0]  pmem_sel_q,     pmem_sel_d;
    logic [LINE_W-1:0] mem_rdata_q,    mem_rdata_d;

    logic              ibuf_hit;
    logic [LINE_W-1:0] ibuf_data;
    logic              buf_fill;
    logic              buf_inv;

    logic              dreq;
    logic              imiss;
    logic              grant_data;
    logic              grant_fetch;

    iline_buffer #(
        .LINE_W (LINE_W),
        .ADR_W  (ADR_W)
    ) u_iline_buffer (
        .clk           (clk),
        .rst_n         (rst_n),
        .lookup_read_i (ifetch_read),
        .lookup_addr_i (ifetch_address),
        .hit_o         (ibuf_hit),
        .data_o        (ibuf_data),
        .fill_i        (buf_fill),
        .fill_addr_i   (pmem_address_q),
        .fill_data_i   (pmem_rdata),
        .inv_i         (buf_inv),
        .inv_addr_i    (pmem_address_q)
    );

    // Arbitration candidates, only acted on in IDLE. On a tie the port that
    // did not win last time is served.
    assign dreq        = mem_read | mem_write;
    assign imiss       = ifetch_read & ~ibuf_hit;
    assign grant_data  = dreq & (~imiss | (last_grant_q == GRANT_FETCH));
    assign grant_fetch = imiss & ~grant_data;

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        pmem_read_d    = pmem_read_q;
        pmem_write_d   = pmem_write_q;
        pmem_address_d = pmem_address_q;
        pmem_wdata_d   = pmem_wdata_q;
        pmem_sel_d     = pmem_sel_q;
        mem_rdata_d    = mem_rdata_q;
        buf_fill       = 1'b0;
        buf_inv        = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_data) begin
                    last_grant_d   = GRANT_DATA;
                    pmem_address_d = mem_address;
                    pmem_wdata_d   = mem_wdata;
                    // Write wins if a requester raises both strobes.
                    pmem_write_d   = mem_write;
                    pmem_read_d    = mem_read & ~mem_write;
                    pmem_sel_d     = mem_write ? mem_sel : '0;
                    state_d        = DACC;
                end else if (grant_fetch) begin
                    last_grant_d   = GRANT_FETCH;
                    pmem_address_d = ifetch_address;
                    pmem_read_d    = 1'b1;
                    pmem_write_d   = 1'b0;
                    pmem_sel_d     = '0;
                    state_d        = IFILL;
                end
            end

            IFILL: begin
                // The line is installed under the latched address even if the
                // fetch address moved on; the next IDLE cycle simply misses.
                if (pmem_resp) begin
                    buf_fill    = 1'b1;
                    pmem_read_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            DACC: begin
                if (pmem_resp) begin
                    if (pmem_read_q) begin
                        mem_rdata_d = pmem_rdata;
                    end
                    // A store to the buffered line makes the buffer stale.
                    if (pmem_write_q) begin
                        buf_inv = 1'b1;
                    end
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                    state_d      = DRESP;
                end
            end

            DRESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            last_grant_q   <= GRANT_FETCH;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
            pmem_sel_q     <= '0;
            mem_rdata_q    <= '0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            pmem_read_q    <= pmem_read_d;
            pmem_write_q   <= pmem_write_d;
            pmem_address_q <= pmem_address_d;
            pmem_wdata_q   <= pmem_wdata_d;
            pmem_sel_q     <= pmem_sel_d;
            mem_rdata_q    <= mem_rdata_d;
        end
    end

    assign ifetch_resp  = ibuf_hit;
    assign ifetch_rdata = ibuf_data;
    assign mem_rdata    = mem_rdata_q;
    assign mem_resp     = (state_q == DRESP);
    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = pmem_address_q;
    assign pmem_wdata   = pmem_wdata_q;
    assign pmem_sel     = pmem_sel_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed scenarios followed by randomized fetch/read/write traffic against
//   a reference model of memory contents and of the one-line buffer.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
    import lc3b_types::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          ifetch_read;
    logic [11:0]   ifetch_address;
    logic [127:0]  ifetch_rdata;
    logic          ifetch_resp;
    logic          mem_read;
    logic          mem_write;
    logic [11:0]   mem_address;
    logic [127:0]  mem_wdata;
    logic [15:0]   mem_sel;
    logic [127:0]  mem_rdata;
    logic          mem_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [11:0]   pmem_address;
    logic [127:0]  pmem_wdata;
    logic [15:0]   pmem_sel;
    logic [127:0]  pmem_rdata;
    logic          pmem_resp;
    lc3b_arb_state dbg_state;

    mem_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ifetch_read    (ifetch_read),
        .ifetch_address (ifetch_address),
        .ifetch_rdata   (ifetch_rdata),
        .ifetch_resp    (ifetch_resp),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_sel        (mem_sel),
        .mem_rdata      (mem_rdata),
        .mem_resp       (mem_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_sel       (pmem_sel),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp),
        .dbg_state_o    (dbg_state)
    );

    // ---------------- counters / reference state ----------------
    int tests_run    = 0;
    int tests_failed = 0;
    int mem_lat      = 3;

    logic [127:0] phys_mem [int];   // contents of the memory model
    logic [127:0] ref_mem  [int];   // contents the requesters expect
    logic [11:0]  ref_tag   = '0;   // line the buffer should hold
    logic         ref_valid = 1'b0;

    function automatic logic [127:0] init_line(input logic [11:0] a);
        return {8{4'hC, a}} ^ {4{a[7:0], 24'h5A3C96}};
    endfunction

    function automatic logic [127:0] ref_line(input logic [11:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return init_line(a);
    endfunction

    function automatic void ref_write(input logic [11:0] a, input logic [127:0] d,
                                      input logic [15:0] s);
        logic [127:0] l;
        l = ref_line(a);
        for (int b = 0; b < 16; b++)
            if (s[b]) l[b*8 +: 8] = d[b*8 +: 8];
        ref_mem[int'(a)] = l;
        if (ref_tag == a) ref_valid = 1'b0;
    endfunction

    // ---------------- physical memory model ----------------
    // Responds mem_lat cycles after a command first appears; forgets any
    // in-flight access when reset is seen.
    int mem_cnt = 0;
    initial begin
        int           key;
        logic [127:0] line;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                pmem_resp = 1'b0;
                mem_cnt   = 0;
            end else if (pmem_resp) begin
                pmem_resp = 1'b0;
                mem_cnt   = 0;
            end else if (pmem_read || pmem_write) begin
                mem_cnt++;
                if (mem_cnt >= mem_lat) begin
                    key  = int'(pmem_address);
                    line = phys_mem.exists(key) ? phys_mem[key] : init_line(pmem_address);
                    if (pmem_write) begin
                        for (int b = 0; b < 16; b++)
                            if (pmem_sel[b]) line[b*8 +: 8] = pmem_wdata[b*8 +: 8];
                        phys_mem[key] = line;
                    end else begin
                        pmem_rdata = line;
                    end
                    pmem_resp = 1'b1;
                end
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_ifetch(input string tag, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!ifetch_resp && cyc < 40);
        if (!ifetch_resp) chk({tag, "_timeout"}, 128'd0, 128'd1);
    endtask

    task automatic wait_mem(input string tag, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!mem_resp && cyc < 40);
        if (!mem_resp) chk({tag, "_timeout"}, 128'd0, 128'd1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_state"},        128'(dbg_state), 128'(IDLE));
        chk({tag, "_pmem_read"},    128'(pmem_read), 128'd0);
        chk({tag, "_pmem_write"},   128'(pmem_write), 128'd0);
        chk({tag, "_pmem_address"}, 128'(pmem_address), 128'd0);
        chk({tag, "_pmem_wdata"},   pmem_wdata, 128'd0);
        chk({tag, "_pmem_sel"},     128'(pmem_sel), 128'd0);
        chk({tag, "_mem_resp"},     128'(mem_resp), 128'd0);
        chk({tag, "_mem_rdata"},    mem_rdata, 128'd0);
        chk({tag, "_ifetch_resp"},  128'(ifetch_resp), 128'd0);
        chk({tag, "_ifetch_rdata"}, ifetch_rdata, 128'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int cyc;
        ifetch_read    = 1'b0;
        ifetch_address = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_wdata      = '0;
        mem_sel        = '0;
        rst_n          = 1'b0;
        repeat (2) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // 1: fetch miss at 0x010, latency 3, then hits
        mem_lat        = 3;
        ifetch_read    = 1'b1;
        ifetch_address = 12'h010;
        tick();
        chk("t1_pmem_read", 128'(pmem_read), 128'd1);
        chk("t1_pmem_addr", 128'(pmem_address), 128'h010);
        chk("t1_pmem_sel",  128'(pmem_sel), 128'd0);
        chk("t1_state",     128'(dbg_state), 128'(IFILL));
        tick();
        tick();
        chk("t1_resp_in_k",   128'(ifetch_resp), 128'd0);
        chk("t1_cmd_held",    128'(pmem_read), 128'd1);
        tick();
        chk("t1_resp_k1",     128'(ifetch_resp), 128'd1);
        chk("t1_line",        ifetch_rdata, ref_line(12'h010));
        chk("t1_cmd_dropped", 128'(pmem_read), 128'd0);
        ref_tag   = 12'h010;
        ref_valid = 1'b1;
        repeat (3) begin
            tick();
            chk("t1_hit",     128'(ifetch_resp), 128'd1);
            chk("t1_no_pmem", 128'(pmem_read), 128'd0);
        end

        // 2: tie, data first (last grant was fetch), then fetch fill
        mem_address    = 12'h020;
        mem_read       = 1'b1;
        ifetch_address = 12'h030;
        tick();
        chk("t2_data_first", 128'(pmem_address), 128'h020);
        chk("t2_rd_sel",     128'(pmem_sel), 128'd0);
        chk("t2_state",      128'(dbg_state), 128'(DACC));
        wait_mem("t2_mem", cyc);
        chk("t2_lat",   128'(cyc), 128'(mem_lat));
        chk("t2_rdata", mem_rdata, ref_line(12'h020));
        mem_read = 1'b0;
        tick();
        chk("t2_one_pulse", 128'(mem_resp), 128'd0);
        tick();
        chk("t2_fetch_next", 128'(pmem_read), 128'd1);
        chk("t2_fetch_addr", 128'(pmem_address), 128'h030);
        chk("t2_rdata_held", mem_rdata, ref_line(12'h020));
        wait_ifetch("t2_fill", cyc);
        chk("t2_fill_line", ifetch_rdata, ref_line(12'h030));
        ref_tag = 12'h030;

        // lone data access (fetch hits), so the next tie goes to fetch
        mem_address = 12'h060;
        mem_read    = 1'b1;
        wait_mem("t2b_mem", cyc);
        chk("t2b_rdata", mem_rdata, ref_line(12'h060));
        mem_read = 1'b0;
        tick();
        mem_address    = 12'h080;
        mem_read       = 1'b1;
        ifetch_address = 12'h070;
        tick();
        chk("t2b_fetch_wins", 128'(pmem_address), 128'h070);
        chk("t2b_state",      128'(dbg_state), 128'(IFILL));
        wait_ifetch("t2b_fill", cyc);
        chk("t2b_fill_line", ifetch_rdata, ref_line(12'h070));
        ref_tag = 12'h070;
        wait_mem("t2b_mem2", cyc);
        chk("t2b_rdata2", mem_rdata, ref_line(12'h080));
        mem_read = 1'b0;
        tick();

        // 3: store to the buffered line invalidates it
        ifetch_address = 12'h010;
        wait_ifetch("t3_refill", cyc);
        chk("t3_line", ifetch_rdata, ref_line(12'h010));
        ref_tag     = 12'h010;
        mem_address = 12'h010;
        mem_wdata   = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
        mem_sel     = 16'h0003;
        mem_write   = 1'b1;
        tick();
        chk("t3_pmem_write", 128'(pmem_write), 128'd1);
        chk("t3_pmem_read",  128'(pmem_read), 128'd0);
        chk("t3_pmem_sel",   128'(pmem_sel), 128'h0003);
        chk("t3_pmem_wdata", pmem_wdata, mem_wdata);
        chk("t3_pmem_addr",  128'(pmem_address), 128'h010);
        ref_write(12'h010, mem_wdata, mem_sel);
        wait_mem("t3_mem", cyc);
        mem_write = 1'b0;
        chk("t3_invalidated", 128'(ifetch_resp), 128'd0);
        wait_ifetch("t3_refill2", cyc);
        chk("t3_merged_line", ifetch_rdata, ref_line(12'h010));
        ref_tag   = 12'h010;
        ref_valid = 1'b1;

        // 4: fetch address changes during the fill
        ifetch_address = 12'h040;
        tick();
        chk("t4_fill_040", 128'(pmem_address), 128'h040);
        ifetch_address = 12'h050;
        tick();
        chk("t4_no_resp_a", 128'(ifetch_resp), 128'd0);
        tick();
        chk("t4_no_resp_b", 128'(ifetch_resp), 128'd0);
        tick();
        chk("t4_no_resp_c", 128'(ifetch_resp), 128'd0);
        chk("t4_holds_040", ifetch_rdata, ref_line(12'h040));
        tick();
        chk("t4_refetch",   128'(pmem_read), 128'd1);
        chk("t4_addr_050",  128'(pmem_address), 128'h050);
        wait_ifetch("t4_fill", cyc);
        chk("t4_line_050", ifetch_rdata, ref_line(12'h050));
        ref_tag = 12'h050;

        // 5: reset in the middle of a data access
        ifetch_read = 1'b0;
        mem_lat     = 10;
        mem_address = 12'h0A0;
        mem_read    = 1'b1;
        tick();
        chk("t5_in_dacc", 128'(dbg_state), 128'(DACC));
        tick();
        rst_n = 1'b0;
        #1;
        check_all_zero("t5_rst");
        ref_valid = 1'b0;
        tick();
        tick();
        mem_lat = 2;
        rst_n   = 1'b1;
        tick();
        chk("t5_regrant", 128'(pmem_read), 128'd1);
        chk("t5_addr",    128'(pmem_address), 128'h0A0);
        wait_mem("t5_mem", cyc);
        chk("t5_rdata", mem_rdata, ref_line(12'h0A0));
        mem_read = 1'b0;
        tick();

        // 6: randomized traffic over a few lines
        for (int i = 0; i < 60; i++) begin
            int          op;
            logic [11:0] a;
            logic        exp_hit;
            logic        is_wr;
            op      = $urandom_range(0, 2);
            a       = 12'h100 + 12'($urandom_range(0, 3));
            mem_lat = $urandom_range(1, 4);
            if (op == 0) begin
                ifetch_read    = 1'b1;
                ifetch_address = a;
                #1;
                exp_hit = ref_valid && (ref_tag == a);
                chk("r_hit", 128'(ifetch_resp), 128'(exp_hit));
                if (!exp_hit) begin
                    wait_ifetch("r_fill", cyc);
                    chk("r_fill_lat", 128'(cyc), 128'(mem_lat + 1));
                    ref_tag   = a;
                    ref_valid = 1'b1;
                end
                chk("r_iline", ifetch_rdata, ref_line(a));
                ifetch_read = 1'b0;
            end else begin
                is_wr       = (op == 2);
                mem_address = a;
                mem_wdata   = {$urandom, $urandom, $urandom, $urandom};
                mem_sel     = 16'($urandom);
                mem_read    = !is_wr;
                mem_write   = is_wr;
                tick();
                chk("r_cmd_addr",  128'(pmem_address), 128'(a));
                chk("r_cmd_write", 128'(pmem_write), 128'(is_wr));
                chk("r_cmd_sel",   128'(pmem_sel), is_wr ? 128'(mem_sel) : 128'd0);
                if (is_wr) ref_write(a, mem_wdata, mem_sel);
                wait_mem("r_mem", cyc);
                chk("r_mem_lat", 128'(cyc), 128'(mem_lat));
                if (!is_wr) chk("r_rdata", mem_rdata, ref_line(a));
                mem_read  = 1'b0;
                mem_write = 1'b0;
                tick();
                chk("r_pulse", 128'(mem_resp), 128'd0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
